// File: rtl/pwm_soc_pkg.sv
// rtl/pwm_soc_pkg.sv - shared types and constants for the PWM demo SoC
package pwm_soc_pkg;

    typedef enum logic {
        BREATHE = 1'b0,
        MANUAL  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    // Received byte that returns the SoC to the breathing pattern
    localparam logic [7:0] MODE_SEL_BYTE = 8'h42;

    function automatic int bit_cyc(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/pwm_soc_if.sv
// rtl/pwm_soc_if.sv - byte link between the PWM core and the UART
interface pwm_soc_if;

    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;

    modport master (
        input  rx_tdata,
        input  rx_tvalid,
        output tx_tdata,
        output tx_tvalid
    );

    modport slave (
        output rx_tdata,
        output rx_tvalid,
        input  tx_tdata,
        input  tx_tvalid
    );

endinterface

// File: rtl/pwm_soc_uart.sv
// rtl/pwm_soc_uart.sv - 8N1 UART: synchronized receiver, transmitter with one-byte holding buffer
module uart_8n1
    import pwm_soc_pkg::*;
#(
    parameter int BIT_CYC = 104
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      rxd_i,
    output logic      txd_o,
    pwm_soc_if.slave  bus
);

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);

    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_valid_q, rx_valid_d;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        txd_q, txd_d;
    logic        take_direct;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            UART_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) rx_state_d = UART_START;
            end
            UART_START: if (rx_cnt_q == HALF_LAST) begin
                // Re-check mid start bit so a glitch does not start a frame
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rxd_sync_q ? UART_IDLE : UART_DATA;
            end
            UART_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == 3'd7) rx_state_d = UART_STOP;
            end
            UART_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = UART_IDLE;
                rx_valid_d = rxd_sync_q;
            end
            default: rx_state_d = UART_IDLE;
        endcase
    end

    assign bus.rx_tdata  = rx_shift_q;
    assign bus.rx_tvalid = rx_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + 16'd1;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        take_direct = 1'b0;
        case (tx_state_q)
            UART_IDLE: begin
                tx_cnt_d = '0;
                if (buf_full_q) begin
                    tx_shift_d = buf_q;
                    buf_full_d = 1'b0;
                    tx_state_d = UART_START;
                end else if (bus.tx_tvalid) begin
                    tx_shift_d  = bus.tx_tdata;
                    take_direct = 1'b1;
                    tx_state_d  = UART_START;
                end
            end
            UART_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_state_d = UART_DATA;
            end
            UART_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_idx_d   = tx_idx_q + 3'd1;
                if (tx_idx_q == 3'd7) tx_state_d = UART_STOP;
            end
            UART_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = UART_IDLE;
            end
            default: tx_state_d = UART_IDLE;
        endcase
        // A byte arriving while the buffer is still occupied is dropped
        if (bus.tx_tvalid && !take_direct && !buf_full_d) begin
            buf_d      = bus.tx_tdata;
            buf_full_d = 1'b1;
        end
        case (tx_state_d)
            UART_START: txd_d = 1'b0;
            UART_DATA:  txd_d = tx_shift_d[0];
            default:    txd_d = 1'b1;
        endcase
    end

    assign txd_o = txd_q;

endmodule

// File: rtl/pwm_soc.sv
// rtl/pwm_soc.sv - demo SoC top: breathing/manual PWM, LED bar and UART echo
module pwm_soc
    import pwm_soc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD        = 115_200,
    parameter int STEP_CYCLES = 46_875
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic       TXD,
    output logic       PWM,
    output logic [3:0] LEDS
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ_HZ, BAUD);
    localparam int SW      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    pwm_soc_if byte_if ();

    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    active_q, active_d;
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic [3:0]    leds_q, leds_d;
    logic          dir_up_q, dir_up_d;
    mode_e         mode_q, mode_d;
    logic [SW-1:0] step_q, step_d;
    logic          echo_valid_q, echo_valid_d;
    logic [7:0]    echo_data_q, echo_data_d;
    logic          step_expire;

    uart_8n1 #(.BIT_CYC(BIT_CYC)) u_uart (
        .clk_i (CLK),
        .rst_i (RESET),
        .rxd_i (RXD),
        .txd_o (TXD),
        .bus   (byte_if)
    );

    assign byte_if.tx_tdata  = echo_data_q;
    assign byte_if.tx_tvalid = echo_valid_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q        <= '0;
            active_q     <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
            leds_q       <= '0;
            dir_up_q     <= 1'b1;
            mode_q       <= BREATHE;
            step_q       <= '0;
            echo_valid_q <= 1'b0;
            echo_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            leds_q       <= leds_d;
            dir_up_q     <= dir_up_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            echo_valid_q <= echo_valid_d;
            echo_data_q  <= echo_data_d;
        end
    end

    always_comb begin
        cnt_d        = cnt_q + 8'd1;
        // Latch the duty only at the wrap so each period is whole
        active_d     = (cnt_q == 8'hFF) ? duty_q : active_q;
        pwm_d        = (cnt_q < active_q);
        leds_d       = duty_q[7:4];
        duty_d       = duty_q;
        dir_up_d     = dir_up_q;
        mode_d       = mode_q;
        step_d       = step_q;
        step_expire  = 1'b0;
        echo_valid_d = byte_if.rx_tvalid;
        echo_data_d  = byte_if.rx_tdata;

        if (mode_q == BREATHE) begin
            if (step_q == STEP_LAST) begin
                step_d      = '0;
                step_expire = 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end

        if (step_expire) begin
            if (dir_up_q) begin
                if (duty_q == 8'hFF) begin
                    duty_d   = 8'hFE;
                    dir_up_d = 1'b0;
                end else begin
                    duty_d = duty_q + 8'd1;
                    if (duty_q == 8'hFE) dir_up_d = 1'b0;
                end
            end else begin
                if (duty_q == 8'h00) begin
                    duty_d   = 8'h01;
                    dir_up_d = 1'b1;
                end else begin
                    duty_d = duty_q - 8'd1;
                    if (duty_q == 8'h01) dir_up_d = 1'b1;
                end
            end
        end

        // A received byte overrides any breathing step landing in the same cycle
        if (byte_if.rx_tvalid) begin
            if (byte_if.rx_tdata == MODE_SEL_BYTE) begin
                mode_d = BREATHE;
            end else begin
                mode_d = MANUAL;
                duty_d = byte_if.rx_tdata;
            end
        end
    end

    assign PWM  = pwm_q;
    assign LEDS = leds_q;

endmodule

// File: tb/tb_pwm_soc.sv
// tb/tb_pwm_soc.sv - scoreboard bench for pwm_soc breathing, manual duty and UART echo
module tb_pwm_soc;

    localparam int BIT = 16;

    logic       CLK = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       txd_a, txd_b, pwm_a, pwm_b;
    logic [3:0] leds_a, leds_b;

    int checks = 0;
    int fails  = 0;
    int echo_seen = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    pwm_soc #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .STEP_CYCLES(256)) dut_a (
        .CLK(CLK), .RESET(rst_a), .RXD(rxd_a), .TXD(txd_a), .PWM(pwm_a), .LEDS(leds_a)
    );

    pwm_soc #(.CLK_FREQ_HZ(1_600_000), .BAUD(100_000), .STEP_CYCLES(4)) dut_b (
        .CLK(CLK), .RESET(rst_b), .RXD(rxd_b), .TXD(txd_b), .PWM(pwm_b), .LEDS(leds_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            rxd_b = frame[i];
            repeat (BIT - 1) @(negedge CLK);
        end
        @(negedge CLK);
        rxd_b = 1'b1;
    endtask

    task automatic wait_echo(input int target);
        int n;
        n = 0;
        while (echo_seen < target && n < 2000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("echo_count", echo_seen, target);
    endtask

    task automatic count_pwm_b(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge CLK); #1;
            hi += int'(pwm_b);
        end
    endtask

    task automatic watch_breathe(output logic [7:0] first, output logic [7:0] second);
        int n;
        n = 0;
        while (dut_b.duty_q == 8'h80 && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        first = dut_b.duty_q;
        n = 0;
        while (dut_b.duty_q == first && n < 16) begin
            @(posedge CLK); #1;
            n++;
        end
        second = dut_b.duty_q;
    endtask

    // Echo monitor: decodes TXD frames at bit centres and pops the scoreboard
    initial begin : tx_monitor
        logic [7:0] got;
        logic       start_ok, stop_ok, aborted;
        forever begin
            @(posedge CLK); #1;
            if (!rst_b && !txd_b) begin
                got = '0; start_ok = 1'b0; stop_ok = 1'b0; aborted = 1'b0;
                for (int n = 1; n <= 9 * BIT + BIT / 2; n++) begin
                    @(posedge CLK); #1;
                    if (rst_b) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (n == BIT / 2) start_ok = !txd_b;
                    else if (n % BIT == BIT / 2) begin
                        if (n / BIT <= 8) got[n / BIT - 1] = txd_b;
                        else stop_ok = txd_b;
                    end
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL echo_unexpected: got %02h expected no echo", got);
                    end else begin
                        check("echo_byte", got, exp_q.pop_front());
                        check("echo_start_bit", start_ok, 1);
                        check("echo_stop_bit", stop_ok, 1);
                    end
                    echo_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hi [4];
        int txd_low, leds_nz, n, since, md;
        logic up;
        logic [7:0] f1, f2;

        // Breathing from reset, one duty step per PWM period
        repeat (4) @(posedge CLK);
        check("reset_pwm", pwm_a, 0);
        check("reset_txd", txd_a, 1);
        check("reset_leds", leds_a, 0);
        @(negedge CLK);
        rst_a = 1'b0;
        hi = '{0, 0, 0, 0};
        txd_low = 0; leds_nz = 0;
        for (int e = 1; e <= 4096; e++) begin
            @(posedge CLK); #1;
            if (e <= 1024) begin
                hi[(e - 1) / 256] += int'(pwm_a);
                txd_low += int'(!txd_a);
            end
            leds_nz += int'(leds_a != 4'h0);
        end
        // The first step coincides with a wrap, so active duty lags one period
        check("pwm_period0", hi[0], 0);
        check("pwm_period1", hi[1], 0);
        check("pwm_period2", hi[2], 1);
        check("pwm_period3", hi[3], 2);
        check("txd_idle_low_cycles", txd_low, 0);
        check("leds_before_duty16", leds_nz, 0);
        @(posedge CLK); #1;
        check("leds_at_duty16", leds_a, 1);

        // Breathe turnaround at 255 and 0
        @(negedge CLK);
        rst_b = 1'b0;
        md = 0; up = 1'b1; since = 0;
        for (int k = 0; k < 520; k++) begin
            n = 0;
            while (dut_b.duty_q == 8'(md) && n < 16) begin
                @(posedge CLK); #1;
                n++; since++;
            end
            if (up) md++; else md--;
            if (md == 255) up = 1'b0;
            if (md == 0) up = 1'b1;
            check("breathe_duty", dut_b.duty_q, md);
            check("breathe_interval", since, 4);
            since = 0;
        end

        // Manual duty 0x80
        @(negedge CLK); rst_b = 1'b1;
        repeat (3) @(negedge CLK);
        rst_b = 1'b0;
        exp_q.push_back(8'h80);
        send_byte(8'h80, 1'b1);
        wait_echo(1);
        repeat (300) @(posedge CLK);
        count_pwm_b(n);
        check("manual_pwm_high", n, 128);
        check("manual_leds", leds_b, 8);
        check("manual_duty", dut_b.duty_q, 8'h80);

        // Framing error: stop bit low, byte discarded and not echoed
        send_byte(8'h07, 1'b0);
        repeat (400) @(posedge CLK);
        check("framing_duty", dut_b.duty_q, 8'h80);
        check("framing_leds", leds_b, 8);
        check("framing_no_echo", echo_seen, 1);

        // 0x42 resumes breathing upward from 0x80
        exp_q.push_back(8'h42);
        fork
            send_byte(8'h42, 1'b1);
            watch_breathe(f1, f2);
        join
        check("breathe_resume_1", f1, 8'h81);
        check("breathe_resume_2", f2, 8'h82);
        wait_echo(2);

        // Back-to-back bytes, second leaves through the holding buffer
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_echo(4);
        check("b2b_leds", leds_b, 2);
        check("b2b_duty", dut_b.duty_q, 8'h22);

        // Reset in the middle of the buffered echo
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        wait_echo(5);
        n = 0;
        while (txd_b && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        check("second_echo_started", txd_b, 0);
        repeat (3 * BIT) @(posedge CLK);
        @(negedge CLK);
        rst_b = 1'b1;
        @(posedge CLK); #1;
        check("reset_mid_txd", txd_b, 1);
        check("reset_mid_pwm", pwm_b, 0);
        check("reset_mid_leds", leds_b, 0);
        repeat (3) @(negedge CLK);
        rst_b = 1'b0;
        repeat (400) @(posedge CLK);
        #1;
        check("no_resumed_echo", echo_seen, 5);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pwm_soc.md
# pwm_soc

Top-level demo SoC block that drives a PWM output, a 4-bit LED bar and a UART. After reset it runs an autonomous "breathing" PWM pattern. Bytes received on the UART select manual duty or breathing mode and are echoed back. It sits at the board top level, directly on the FPGA pins.

## Interface
Parameters:
- CLK_FREQ_HZ, 12_000_000: clock frequency.
- BAUD, 115_200: UART bit rate. Bit period BIT_CYC = CLK_FREQ_HZ/BAUD (integer division; 104 at defaults).
- STEP_CYCLES, 46_875: clocks between breathing duty steps.

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high reset.
- RXD  in  1  UART receive, idle high, asynchronous to CLK.
- TXD  out  1  UART transmit, idle high.
- PWM  out  1  PWM output.
- LEDS  out  4  LED bar.

## Operation
- Reset values:
  - PWM=0, TXD=1, LEDS=0.
  - duty=0, active_duty=0, PWM counter=0, direction=up, mode=BREATHE.
  - UART RX/TX idle, holding buffer empty.
- PWM generation:
  - 8-bit counter increments every clock and wraps 255→0.
  - PWM = (counter < active_duty), registered.
  - active_duty loads from duty only when the counter wraps to 0, so every period is glitch-free.
  - duty=0 gives constant 0. duty=255 gives 255 high cycles out of 256.
- BREATHE mode:
  - A step timer counts STEP_CYCLES clocks. On expiry, duty moves ±1.
  - On reaching 255 the direction flips to down. On reaching 0 it flips to up.
  - duty never wraps.
- MANUAL mode: duty holds the last received data byte; the step timer is frozen.
- LEDS = duty[7:4], registered.
- UART RX (8N1):
  - RXD passes through a 2-flop synchronizer.
  - Idle → START: entered on a falling edge.
  - START: samples at BIT_CYC/2. If the line is high, the start is false and RX returns to idle.
  - DATA: 8 bits sampled at bit centers, LSB first.
  - STOP: sampled at bit center. If 0, this is a framing error and the byte is discarded.
- Byte handling for a valid byte b:
  - b=0x42 ('B') sets mode=BREATHE. duty continues from its current value and direction.
  - Any other b sets mode=MANUAL and duty=b.
  - Every valid byte, including 0x42, is queued for echo.
- UART TX (8N1):
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BIT_CYC clocks.
  - One-byte holding buffer. If TX is idle the byte starts immediately; if busy it waits in the buffer.
  - If the buffer is already full, the new echo byte is dropped. Mode and duty are still updated.
- RESET mid-frame: both UART state machines abort at once; TXD returns to 1 in the next cycle.

## Timing
- Single clock edge domain; all outputs registered.
- Duty change → PWM effect: at the next counter wrap, at most 256 clocks.
- RX completion: valid-byte strobe occurs at the stop-bit center sample, 9.5×BIT_CYC clocks after the falling edge, plus 2 synchronizer cycles.
- Byte effects: mode/duty update in the cycle after the RX strobe. The TX start bit begins the cycle after that if TX is idle.
- Simultaneous events:
  - A step-timer expiry in the same cycle as an RX byte: the RX byte takes priority for duty.
  - A duty change coinciding with a counter wrap: active_duty loads the old duty; the new duty applies from the next wrap.
- PWM period: 256 clocks (46.875 kHz at defaults). A full breathe cycle is 510 steps.

## Structure
- Shared package pwm_soc_pkg contains:
  - mode enum {BREATHE, MANUAL};
  - UART state enum {IDLE, START, DATA, STOP};
  - BIT_CYC function;
  - the 0x42 mode-select constant.
- One sub-module: uart_8n1 (RX with synchronizer, TX with holding buffer; byte in/out valid strobes).
- The PWM counter, breathe engine and LED logic stay in pwm_soc.

## Test plan
- Reset, then 2 PWM periods with STEP_CYCLES overridden to 256: TXD=1 throughout. PWM high for active_duty cycles per period (0, then 1, 2, …). LEDS=0 until duty reaches 16.
- Breathe turnaround with STEP_CYCLES=4: duty reaches 255, then next steps are 254, 253. At 0 it turns back up; no wrap to 255.
- Send 0x80 on RXD: after the next wrap PWM is high 128 of 256 clocks. LEDS=0x8. TXD echoes 0x80 with 10 bits of BIT_CYC each.
- Send 0x42: mode returns to BREATHE (duty steps from 0x80). Echo 0x42.
- Send a frame with stop bit 0: no duty/mode change, no echo.
- Send two back-to-back bytes 0x11, 0x22: both echoed in order (second from the holding buffer). Assert RESET during the second echo: TXD=1 on the next cycle, and PWM/LEDS return to 0.
